display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
Time-multiplexes the single seven-segment display among four metric sources (steps, distance, speed-check, high-activity), replacing the derived-clock cycle counter with a clk-domain scheduler. Rotates round-robin through enabled slots, dwelling a programmable number of seconds per slot. Supports hold, manual advance and per-slot masking. Outputs feed the display driver's 16-bit value input and its alt/decimal-mode input directly.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per one-second tick
DWELL_SEC, 2, seconds each slot is shown before auto-advance (>=1)
SEC_W, 8, width of seconds counter (must hold DWELL_SEC-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; high = rotation enabled
hold  in  1  level; high = freeze on current slot, dwell timing paused
next_btn  in  1  raw pushbutton (asynchronous), manual advance
slot_en  in  4  per-slot enable mask; bit i enables slot i
alt_mask  in  4  per-slot alt-display flag (distance slot = bit 1)
val0  in  16  slot 0 value (step count)
val1  in  16  slot 1 value (distance)
val2  in  16  slot 2 value (speed-check seconds)
val3  in  16  slot 3 value (high-activity time)
seg_val  out  16  value to display driver
seg_alt  out  1  alt flag to display driver
cur_slot  out  2  index of slot being shown
slot_change  out  1  one-cycle pulse on every slot change

Behaviour:
- Reset (async, asserted): state=IDLE, cur_slot=0, seg_val=0, seg_alt=0, slot_change=0, prescaler=0, sec_cnt=0, button sync flops=0.
- States: IDLE (start=0), RUN (start=1, hold=0), HOLD (start=1, hold=1). Evaluated each cycle from inputs; hold dominates start only when start=1.
- Prescaler: counts 0..TICKS_PER_SEC-1 in RUN only; wrap = sec tick. On tick, if sec_cnt==DWELL_SEC-1 -> advance, sec_cnt=0; else sec_cnt++.
- HOLD: prescaler and sec_cnt frozen (resume where left). IDLE: both cleared to 0, cur_slot kept.
- Effective mask: eff_en = (slot_en==0) ? 4'b0001 : slot_en.
- Advance: cur_slot <= first i in cur+1, cur+2, cur+3, cur (mod 4) with eff_en[i]=1. Single enabled slot -> cur_slot unchanged, slot_change not pulsed.
- Disabled current slot: if eff_en[cur_slot]=0 in any state, advance next cycle (forced), prescaler/sec_cnt cleared.
- Manual: next_btn passes 2-flop synchronizer; rising edge of synced signal -> advance in IDLE, RUN or HOLD; prescaler and sec_cnt cleared. Latency from raw edge to cur_slot change: 3 clk.
- Simultaneous events (button edge, dwell expiry, forced advance in same cycle): exactly one advance, counters cleared.
- seg_val <= val[cur_slot], seg_alt <= alt_mask[cur_slot], registered every cycle (live values, 1-cycle latency after cur_slot or val change).
- slot_change = 1 for exactly the cycle after cur_slot takes a new value.
- Reset mid-dwell: everything returns to reset values immediately; rotation restarts from slot 0 with full dwell.

Test Plan:
- TICKS_PER_SEC=4, DWELL_SEC=2, slot_en=1111, start=1 after reset -> cur_slot 0,1,2,3,0 changing every 8 clk; slot_change pulses once per change; seg_alt=1 only while cur_slot=1.
- slot_en=1010, start=1 -> cur_slot alternates 1,3,1 every 8 clk (first forced move 0->1 one cycle after reset release); slot_en=0000 -> cur_slot settles to 0, no further changes.
- hold=1 for 20 clk after 5 clk into a dwell, then hold=0 -> advance occurs 3 clk after release (total 8 RUN cycles), no advance during hold.
- next_btn pulse (>=3 clk) in IDLE at cur_slot=2 -> cur_slot=3 three clk after edge; button edge coinciding with dwell expiry in RUN -> single advance, next auto-advance 8 clk later.
- val2 changes 0x0010->0x0011 while cur_slot=2 -> seg_val follows 1 clk later; switch to slot 3 with val3=0x0042 -> seg_val=0x0042 one clk after cur_slot=3.
- Assert reset mid-dwell at cur_slot=3, sec_cnt=1 -> outputs 0 asynchronously; after release with start=1, first advance to slot 1 after full 8 clk.

Source files
------------

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin scheduler that time-multiplexes four metric slots onto one display
module display_scheduler #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int DWELL_SEC     = 2,
   parameter int SEC_W         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        hold,
   input  logic        next_btn,
   input  logic [3:0]  slot_en,
   input  logic [3:0]  alt_mask,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [15:0] val2,
   input  logic [15:0] val3,
   output logic [15:0] seg_val,
   output logic        seg_alt,
   output logic [1:0]  cur_slot,
   output logic        slot_change
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]      r_slot;
   logic [15:0]     r_seg_val;
   logic            r_seg_alt;
   logic            r_slot_change;
   logic [PW-1:0]   r_presc;
   logic [SEC_W-1:0] r_sec;
   logic            r_btn_s1;
   logic            r_btn_s2;
   logic            r_btn_prev;

   logic [1:0]      w_state;
   logic [3:0]      w_eff_en;
   logic [1:0]      w_next;
   logic            w_tick;
   logic            w_dwell_done;
   logic            w_btn_edge;
   logic            w_forced;
   logic            w_adv;
   logic [15:0]     w_val_sel;

   always_comb begin
      w_state = ST_IDLE;
      if (start)
         w_state = hold ? ST_HOLD : ST_RUN;
   end

   // An all-zero mask falls back to slot 0 so the display never goes blank.
   assign w_eff_en = (slot_en == 4'b0000) ? 4'b0001 : slot_en;

   // Descending scan so the nearest enabled slot after the current one wins.
   always_comb begin
      w_next = r_slot;
      for (int k = 3; k >= 1; k--) begin
         if (w_eff_en[r_slot + 2'(k)])
            w_next = r_slot + 2'(k);
      end
   end

   assign w_tick       = (w_state == ST_RUN) && (r_presc == PW'(TICKS_PER_SEC - 1));
   assign w_dwell_done = w_tick && (r_sec == SEC_W'(DWELL_SEC - 1));
   assign w_btn_edge   = r_btn_s2 & ~r_btn_prev;
   assign w_forced     = ~w_eff_en[r_slot];
   assign w_adv        = w_forced | w_btn_edge | w_dwell_done;

   always_comb begin
      case (r_slot)
         2'd0:    w_val_sel = val0;
         2'd1:    w_val_sel = val1;
         2'd2:    w_val_sel = val2;
         default: w_val_sel = val3;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_s1   <= 1'b0;
         r_btn_s2   <= 1'b0;
         r_btn_prev <= 1'b0;
      end else begin
         r_btn_s1   <= next_btn;
         r_btn_s2   <= r_btn_s1;
         r_btn_prev <= r_btn_s2;
      end
   end

   // Any advance source restarts the dwell from zero; HOLD simply freezes both counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot        <= 2'd0;
         r_slot_change <= 1'b0;
         r_presc       <= '0;
         r_sec         <= '0;
      end else begin
         r_slot_change <= w_adv && (w_next != r_slot);
         if (w_adv) begin
            r_slot  <= w_next;
            r_presc <= '0;
            r_sec   <= '0;
         end else if (w_state == ST_IDLE) begin
            r_presc <= '0;
            r_sec   <= '0;
         end else if (w_state == ST_RUN) begin
            if (w_tick) begin
               r_presc <= '0;
               r_sec   <= r_sec + SEC_W'(1);
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_val <= 16'h0000;
         r_seg_alt <= 1'b0;
      end else begin
         r_seg_val <= w_val_sel;
         r_seg_alt <= alt_mask[r_slot];
      end
   end

   assign seg_val     = r_seg_val;
   assign seg_alt     = r_seg_alt;
   assign cur_slot    = r_slot;
   assign slot_change = r_slot_change;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
module tb_display_scheduler;

   logic        clk;
   logic        reset;
   logic        start;
   logic        hold;
   logic        next_btn;
   logic [3:0]  slot_en;
   logic [3:0]  alt_mask;
   logic [15:0] val0, val1, val2, val3;
   logic [15:0] seg_val;
   logic        seg_alt;
   logic [1:0]  cur_slot;
   logic        slot_change;

   typedef struct {
      logic [1:0] slot;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   r0, r2, h0, r3, s0;

   display_scheduler #(
      .TICKS_PER_SEC(4),
      .DWELL_SEC(2),
      .SEC_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .hold(hold),
      .next_btn(next_btn),
      .slot_en(slot_en),
      .alt_mask(alt_mask),
      .val0(val0),
      .val1(val1),
      .val2(val2),
      .val3(val3),
      .seg_val(seg_val),
      .seg_alt(seg_alt),
      .cur_slot(cur_slot),
      .slot_change(slot_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_change(input logic [1:0] slot, input int at);
      exp_t e;
      e.slot = slot;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Each slot_change pulse must match the oldest expected change in slot and cycle.
   always @(negedge clk) begin
      if (!reset && slot_change) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_change", {30'd0, cur_slot}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("change_slot", {30'd0, cur_slot}, {30'd0, e.slot});
            chk("change_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic press(input logic [1:0] slot);
      int e0;
      e0 = cyc;
      next_btn = 1'b1;
      expect_change(slot, e0 + 3);
      wait_cyc(e0 + 4);
      next_btn = 1'b0;
      wait_cyc(e0 + 8);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0; next_btn = 1'b0;
      slot_en = 4'b1111; alt_mask = 4'b0010;
      val0 = 16'h1000; val1 = 16'h1111; val2 = 16'h0010; val3 = 16'h0042;
      @(negedge clk); @(negedge clk);
      chk("rst_cur_slot", {30'd0, cur_slot}, 32'd0);
      chk("rst_seg_val", {16'd0, seg_val}, 32'd0);
      chk("rst_seg_alt", {31'd0, seg_alt}, 32'd0);
      chk("rst_slot_change", {31'd0, slot_change}, 32'd0);

      // rotation through all four slots, 8 clk dwell
      reset = 1'b0; start = 1'b1; r0 = cyc;
      expect_change(2'd1, r0 + 8);
      expect_change(2'd2, r0 + 16);
      expect_change(2'd3, r0 + 24);
      wait_cyc(r0 + 2);
      chk("slot0_val", {16'd0, seg_val}, 32'h1000);
      chk("slot0_alt", {31'd0, seg_alt}, 32'd0);
      wait_cyc(r0 + 9);
      chk("slot1_val", {16'd0, seg_val}, 32'h1111);
      chk("slot1_alt", {31'd0, seg_alt}, 32'd1);
      wait_cyc(r0 + 17);
      chk("slot2_val", {16'd0, seg_val}, 32'h0010);
      chk("slot2_alt", {31'd0, seg_alt}, 32'd0);
      val2 = 16'h0011;
      wait_cyc(r0 + 18);
      chk("slot2_live_val", {16'd0, seg_val}, 32'h0011);
      wait_cyc(r0 + 25);
      chk("slot3_val", {16'd0, seg_val}, 32'h0042);

      // async reset mid-dwell at slot 3 with sec_cnt=1
      wait_cyc(r0 + 29);
      reset = 1'b1;
      #1;
      chk("async_rst_slot", {30'd0, cur_slot}, 32'd0);
      chk("async_rst_val", {16'd0, seg_val}, 32'd0);
      chk("async_rst_alt", {31'd0, seg_alt}, 32'd0);
      wait_cyc(r0 + 31);
      reset = 1'b0; r2 = cyc;
      expect_change(2'd1, r2 + 8);
      expect_change(2'd2, r2 + 16);
      expect_change(2'd3, r2 + 24);
      expect_change(2'd0, r2 + 32);

      // hold 20 clk after 5 run clk of the dwell at slot 0
      wait_cyc(r2 + 37);
      hold = 1'b1; h0 = cyc;
      wait_cyc(h0 + 20);
      chk("hold_no_advance", {30'd0, cur_slot}, 32'd0);
      hold = 1'b0;
      expect_change(2'd1, h0 + 23);

      // forced move off disabled slot 0 after reset with mask 1010
      wait_cyc(h0 + 24);
      reset = 1'b1; slot_en = 4'b1010;
      wait_cyc(h0 + 26);
      reset = 1'b0; r3 = cyc;
      expect_change(2'd1, r3 + 1);
      expect_change(2'd3, r3 + 9);
      expect_change(2'd1, r3 + 17);
      wait_cyc(r3 + 17);
      slot_en = 4'b0000;
      expect_change(2'd0, r3 + 18);
      wait_cyc(r3 + 40);
      chk("empty_mask_slot", {30'd0, cur_slot}, 32'd0);

      // manual advance in IDLE
      start = 1'b0; slot_en = 4'b1111;
      wait_cyc(r3 + 42);
      press(2'd1);
      press(2'd2);
      press(2'd3);
      wait_cyc(cyc + 20);
      chk("idle_no_auto", {30'd0, cur_slot}, 32'd3);

      // button edge coincides with dwell expiry: one advance only
      start = 1'b1; s0 = cyc;
      expect_change(2'd0, s0 + 8);
      expect_change(2'd1, s0 + 16);
      wait_cyc(s0 + 5);
      next_btn = 1'b1;
      wait_cyc(s0 + 10);
      next_btn = 1'b0;
      wait_cyc(s0 + 20);

      chk("all_changes_seen", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog expired actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
